// File: rtl/audio_out_mmio.sv
// Memory-mapped PCM audio output: software fills a sample FIFO, a programmable
// divider drains one sample per tick to the DAC, with status flags and a refill irq.
module audio_out_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          SAMPLE_W   = 16,
  parameter logic [15:0] DIV_RESET  = 16'd1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic                mem_we,
  output logic [31:0]         mem_rdata,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LEVEL_MAX = FIFO_DEPTH[AW:0];

  logic                en_reg;
  logic [7:0]          thresh_reg;
  logic [15:0]         div_reg;
  logic [15:0]         cnt_reg;
  logic                underrun_reg;
  logic                overflow_reg;
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [AW:0]         level_reg;
  logic [SAMPLE_W-1:0] sample_out_reg;
  logic                sample_valid_reg;
  logic [SAMPLE_W-1:0] fifo_mem [FIFO_DEPTH];

  logic       sel;
  logic [1:0] offset;
  logic       wr_ctrl, wr_status, wr_div, wr_data;
  logic       empty, full, flush, tick, pop, push;
  logic [7:0] level8;
  logic       unused_bits;

  assign sel       = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = mem_addr[3:2];
  assign wr_ctrl   = sel & mem_we & (offset == 2'd0);
  assign wr_status = sel & mem_we & (offset == 2'd1);
  assign wr_div    = sel & mem_we & (offset == 2'd2);
  assign wr_data   = sel & mem_we & (offset == 2'd3);

  assign empty  = (level_reg == '0);
  assign full   = (level_reg == LEVEL_MAX);
  assign flush  = wr_ctrl & mem_wdata[1];
  assign tick   = en_reg & (cnt_reg == div_reg);
  // A flush in the same cycle swallows the tick entirely: no pop, no underrun.
  assign pop    = tick & ~flush & ~empty;
  assign push   = wr_data & (~full | pop);
  assign level8 = 8'(level_reg);

  assign unused_bits = ^{mem_addr[1:0], mem_wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg     <= 1'b0;
      thresh_reg <= 8'd0;
      div_reg    <= DIV_RESET;
    end else begin
      if (wr_ctrl) begin
        en_reg     <= mem_wdata[0];
        thresh_reg <= mem_wdata[15:8];
      end
      if (wr_div) div_reg <= mem_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || wr_div || !en_reg || tick) cnt_reg <= 16'd0;
    else                                  cnt_reg <= cnt_reg + 16'd1;
  end

  // Set events take priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      underrun_reg <= (tick & ~flush & empty) | (underrun_reg & ~(wr_status & mem_wdata[2]));
      overflow_reg <= (wr_data & full & ~pop) | (overflow_reg & ~(wr_status & mem_wdata[3]));
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= mem_wdata[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out_reg   <= '0;
      sample_valid_reg <= 1'b0;
    end else begin
      sample_valid_reg <= pop;
      if (pop) sample_out_reg <= fifo_mem[rd_ptr_reg];
    end
  end

  always_comb begin
    mem_rdata = 32'd0;
    if (sel) begin
      case (offset)
        2'd0:    mem_rdata = {16'd0, thresh_reg, 7'd0, en_reg};
        2'd1:    mem_rdata = {16'd0, level8, 4'd0, overflow_reg, underrun_reg, full, empty};
        2'd2:    mem_rdata = {16'd0, div_reg};
        default: mem_rdata = 32'd0;
      endcase
    end
  end

  assign sample_out   = sample_out_reg;
  assign sample_valid = sample_valid_reg;
  assign irq          = en_reg & ({1'b0, thresh_reg} >= 9'(level_reg));

endmodule

// File: tb/tb_audio_out_mmio.sv
// Bench for audio_out_mmio: register table, directed corner sequences and a
// randomized phase, all checked against a queue-based reference model.
module tb_audio_out_mmio;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        irq;

  audio_out_mmio dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .sample_out(sample_out), .sample_valid(sample_valid), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_q[$];
  logic        m_en;
  logic [7:0]  m_thresh;
  logic [15:0] m_div;
  int          m_cnt;
  logic        m_und, m_ovf;
  logic [15:0] m_out;
  logic        m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd0: r = {16'd0, m_thresh, 7'd0, m_en};
        2'd1: r = {16'd0, 8'(m_q.size()), 4'd0, m_ovf, m_und,
                   (m_q.size() == DEPTH), (m_q.size() == 0)};
        2'd2: r = {16'd0, m_div};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  function automatic void model_step(input logic r, input logic [31:0] a,
                                     input logic [31:0] d, input logic w);
    logic sel, wctrl, wstat, wdiv, wdat, tick, flush, pop, und_set, ovf_set, full;
    if (r) begin
      m_q.delete(); m_en = 0; m_thresh = 0; m_div = 16'd1023; m_cnt = 0;
      m_und = 0; m_ovf = 0; m_out = 0; m_valid = 0;
      return;
    end
    sel   = (a[31:4] == BASE[31:4]);
    wctrl = w && sel && a[3:2] == 2'd0;
    wstat = w && sel && a[3:2] == 2'd1;
    wdiv  = w && sel && a[3:2] == 2'd2;
    wdat  = w && sel && a[3:2] == 2'd3;
    tick    = m_en && (m_cnt == int'(m_div));
    flush   = wctrl && d[1];
    full    = (m_q.size() == DEPTH);
    pop     = tick && !flush && m_q.size() > 0;
    und_set = tick && !flush && m_q.size() == 0;
    ovf_set = 0;
    m_valid = pop;
    if (pop) m_out = m_q.pop_front();
    if (wdat) begin
      if (!full || pop) m_q.push_back(d[15:0]);
      else ovf_set = 1;
    end
    if (flush) m_q.delete();
    m_cnt = (wdiv || !m_en || tick) ? 0 : m_cnt + 1;
    m_und = und_set || (m_und && !(wstat && d[2]));
    m_ovf = ovf_set || (m_ovf && !(wstat && d[3]));
    if (wctrl) begin m_en = d[0]; m_thresh = d[15:8]; end
    if (wdiv) m_div = d[15:0];
  endfunction

  // One bus cycle: read-check before the edge, model update and output check after.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
    mem_addr = a; mem_wdata = d; mem_we = w;
    #1;
    if (!w && !rst) chk("rdata", mem_rdata, model_read(a));
    @(posedge clk); #1;
    mem_we = 1'b0;
    model_step(rst, a, d, w);
    chk("sample_out", 32'(sample_out), 32'(m_out));
    chk("sample_valid", 32'(sample_valid), 32'(m_valid));
    chk("irq", 32'(irq), 32'(m_en && (m_q.size() <= int'(m_thresh))));
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    cyc(BASE + 32'(off), d, 1'b1);
  endtask

  task automatic idle();
    cyc(BASE + 32'h4, 32'd0, 1'b0);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] off, input logic [31:0] exp);
    mem_addr = BASE + 32'(off); mem_we = 1'b0;
    #1;
    chk(name, mem_rdata, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(BASE, 32'd0, 1'b0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int n;
    int t[3];
    logic [15:0] v[3];
    logic seen;

    vecs[0]  = '{1'b0, BASE + 32'h0,  32'd0,          32'h0000_0000};
    vecs[1]  = '{1'b0, BASE + 32'h4,  32'd0,          32'h0000_0001};
    vecs[2]  = '{1'b0, BASE + 32'h8,  32'd0,          32'h0000_03FF};
    vecs[3]  = '{1'b0, 32'h9000_0000, 32'd0,          32'h0000_0000};
    vecs[4]  = '{1'b0, BASE + 32'hC,  32'd0,          32'h0000_0000};
    vecs[5]  = '{1'b0, BASE + 32'h10, 32'd0,          32'h0000_0000};
    vecs[6]  = '{1'b1, BASE + 32'h0,  32'hFFFF_FFFE,  32'h0};
    vecs[7]  = '{1'b0, BASE + 32'h0,  32'd0,          32'h0000_FF00};
    vecs[8]  = '{1'b1, BASE + 32'hB,  32'h1234_5678,  32'h0};
    vecs[9]  = '{1'b0, BASE + 32'h8,  32'd0,          32'h0000_5678};
    vecs[10] = '{1'b1, BASE + 32'h4,  32'h0000_000F,  32'h0};
    vecs[11] = '{1'b0, BASE + 32'h4,  32'd0,          32'h0000_0001};
    vecs[12] = '{1'b0, BASE + 32'h7,  32'd0,          32'h0000_0001};
    vecs[13] = '{1'b1, BASE + 32'h0,  32'h0000_0000,  32'h0};
    vecs[14] = '{1'b0, BASE + 32'h0,  32'd0,          32'h0000_0000};

    rst = 1'b1; mem_addr = 32'd0; mem_wdata = 32'd0; mem_we = 1'b0;
    model_step(1'b1, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_valid", 32'(sample_valid), 32'd0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) cyc(vecs[i].addr, vecs[i].data, 1'b1);
      else begin
        mem_addr = vecs[i].addr; mem_we = 1'b0;
        #1;
        chk($sformatf("vec%0d", i), mem_rdata, vecs[i].exp);
      end
    end

    // Playback at DIV=3, then underrun on the tick after the FIFO drains.
    do_reset();
    wr(4'h8, 32'd3);
    wr(4'hC, 32'h1111); wr(4'hC, 32'h2222); wr(4'hC, 32'h3333);
    wr(4'h0, 32'h1);
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      idle();
      if (sample_valid) begin t[n] = c; v[n] = sample_out; n++; end
    end
    chk("seq1_pulses", 32'(n), 32'd3);
    if (n == 3) begin
      chk("seq1_first_at", 32'(t[0]), 32'd3);
      chk("seq1_val0", 32'(v[0]), 32'h1111);
      chk("seq1_val1", 32'(v[1]), 32'h2222);
      chk("seq1_val2", 32'(v[2]), 32'h3333);
      chk("seq1_gap01", 32'(t[1] - t[0]), 32'd4);
      chk("seq1_gap12", 32'(t[2] - t[1]), 32'd4);
    end
    repeat (4) idle();
    rd_chk("seq1_underrun", 4'h4, 32'h0000_0005);
    chk("seq1_hold", 32'(sample_out), 32'h3333);

    // Overflow with EN=0, then W1C of OVERFLOW.
    do_reset();
    for (int i = 0; i < 17; i++) wr(4'hC, 32'hA000 + 32'(i));
    rd_chk("seq2_overflow", 4'h4, 32'h0000_100A);
    wr(4'h4, 32'h8);
    rd_chk("seq2_w1c", 4'h4, 32'h0000_1002);

    // Full FIFO, push on a tick cycle is accepted.
    wr(4'h8, 32'd0);
    wr(4'h0, 32'h1);
    wr(4'hC, 32'hBEEF);
    rd_chk("seq3_full_push", 4'h4, 32'h0000_1002);
    chk("seq3_pop", 32'(sample_valid), 32'd1);

    // Threshold irq follows LEVEL without latency.
    do_reset();
    wr(4'hC, 32'h11); wr(4'hC, 32'h22); wr(4'hC, 32'h33);
    wr(4'h8, 32'd7);
    wr(4'h0, 32'h0201);
    chk("seq4_irq_lo", 32'(irq), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      idle();
      seen = sample_valid;
    end
    chk("seq4_pop_seen", 32'(seen), 32'd1);
    chk("seq4_irq_hi", 32'(irq), 32'd1);
    rd_chk("seq4_level", 4'h4, 32'h0000_0200);

    // Flush on a tick cycle suppresses the tick.
    do_reset();
    wr(4'h8, 32'd3);
    for (int i = 0; i < 5; i++) wr(4'hC, 32'h50 + 32'(i));
    wr(4'h0, 32'h1);
    repeat (3) idle();
    rd_chk("seq5_level5", 4'h4, 32'h0000_0500);
    wr(4'h0, 32'h3);
    chk("seq5_no_valid", 32'(sample_valid), 32'd0);
    rd_chk("seq5_status", 4'h4, 32'h0000_0001);
    rd_chk("seq5_ctrl", 4'h0, 32'h0000_0001);

    // Reset mid-stream.
    for (int i = 0; i < 4; i++) wr(4'hC, 32'h70 + 32'(i));
    repeat (5) idle();
    do_reset();
    chk("rst_out", 32'(sample_out), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd_chk("rst_status", 4'h4, 32'h0000_0001);
    rd_chk("rst_ctrl", 4'h0, 32'h0000_0000);
    rd_chk("rst_div", 4'h8, 32'h0000_03FF);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      int k;
      logic [31:0] d;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3, 4: wr(4'hC, $urandom);
        5: begin
          d = {16'd0, 8'($urandom_range(0, 17)), 6'd0,
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
          wr(4'h0, d);
        end
        6: wr(4'h8, 32'($urandom_range(0, 4)));
        7: wr(4'h4, 32'($urandom_range(0, 15)));
        8: cyc(BASE + 32'($urandom_range(0, 15)), 32'd0, 1'b0);
        default: cyc($urandom, 32'd0, 1'b0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
